// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues one decoded operation at a time to the PE ALU,
// waits for its completion (or abandons it after a timeout) and returns the
// captured result, zero flag, tag and error code over a valid/ready channel.
//
//   state  | meaning
//   IDLE   | ready for a request; operands of the last op still on the ALU bus
//   EXEC   | operands driven to the ALU, waiting for complete or timeout
//   RESP   | response presented, waiting for the consumer to take it
module alu_op_issuer #(
  parameter int TAG_W       = 4,
  parameter int ALU_LATENCY = 1,
  parameter int TIMEOUT     = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [4:0]       req_sel,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_sel,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_complete,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic             resp_zero,
  output logic [TAG_W-1:0] resp_tag,
  output logic [1:0]       resp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Cycle counter only needs to reach TIMEOUT; it never runs past it.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAT_C = TW'(ALU_LATENCY);
  localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT);

  logic [1:0]       state;
  logic [TW-1:0]    cnt;
  logic [TAG_W-1:0] tag_q;
  logic [1:0]       err_q;
  logic [1:0]       err_pre;
  logic             accept;

  // req_ready is gated by rst so every output reads 0 while reset is held.
  assign req_ready  = (state == S_IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  // Classify the incoming op; illegal select outranks divide-by-zero.
  always_comb begin
    err_pre = 2'd0;
    if (req_sel > 5'b10011)
      err_pre = 2'd2;
    else if (req_sel == 5'b00011 && req_b == 32'd0)
      err_pre = 2'd1;
  end

  // Sequence one op: latch operands, wait for the ALU or time out, hand back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tag_q       <= '0;
      err_q       <= 2'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_sel     <= 5'd0;
      resp_result <= 32'd0;
      resp_zero   <= 1'b0;
      resp_tag    <= '0;
      resp_err    <= 2'd0;
      ops_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_sel <= req_sel;
            tag_q   <= req_tag;
            err_q   <= err_pre;
            cnt     <= '0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt >= LAT_C && alu_complete) begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_err    <= err_q;
            resp_tag    <= tag_q;
            state       <= S_RESP;
          end else if (cnt == TMO_C) begin
            // Timeout replaces whatever error was pre-computed.
            resp_result <= 32'hFFFF_FFFF;
            resp_zero   <= 1'b0;
            resp_err    <= 2'd3;
            resp_tag    <= tag_q;
            state       <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            ops_count <= ops_count + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
